// File: rtl/spi_master_controller.sv
// spi_master_controller: memory-mapped SPI master (mode 0, one byte per transfer) for the 68k I/O window.
// Ports: Clk/Reset_L (async active-low); CPU side SPI_Enable_H, Address[3:1], WE_L, DataIn, DataOut, Dtack_L;
// IRQ_L active-low completion interrupt; SPI side SCLK_H, MOSI_H, MISO_H, SS_L[7:0].
module spi_master_controller (
  input  logic       Clk,
  input  logic       Reset_L,
  input  logic       SPI_Enable_H,
  input  logic [2:0] Address,
  input  logic       WE_L,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  output logic       Dtack_L,
  output logic       IRQ_L,
  output logic       SCLK_H,
  output logic       MOSI_H,
  input  logic       MISO_H,
  output logic [7:0] SS_L
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic en_q, strobe, wr, rd, wr_ctrl, wr_stat, wr_data, wr_ss;
  logic spie, spe, spie_n, spe_n, spif, wcol, spif_n, wcol_n, sclk, busy, start, half_end, done;
  logic [1:0] div;
  logic [3:0] cnt, hc, lim;
  logic [7:0] tx, rx, data_rx, ss, rd_val;
  // One register action per 68k cycle: act only on the rising edge of the select.
  assign strobe  = SPI_Enable_H & ~en_q;
  assign wr      = strobe & ~WE_L;
  assign rd      = strobe & WE_L;
  assign wr_ctrl = wr && Address == 3'd0;
  assign wr_stat = wr && Address == 3'd1;
  assign wr_data = wr && Address == 3'd2;
  assign wr_ss   = wr && Address == 3'd3;
  assign busy    = state == SHIFT;
  // Next-cycle CTRL values, so clearing SPE aborts in the same cycle as the write.
  assign spie_n  = wr_ctrl ? DataIn[7] : spie;
  assign spe_n   = wr_ctrl ? DataIn[6] : spe;
  assign start   = wr_data & spe & ~busy;
  // Half-period length minus one: 1/3/7/15 for DIV 0..3.
  assign lim     = {div == 2'd3, div >= 2'd2, div >= 2'd1, 1'b1};
  assign spif_n  = done | (spif & ~(wr_stat & DataIn[7]));
  assign wcol_n  = (wr_data & busy) | (wcol & ~(wr_stat & DataIn[6]));
  assign rd_val  = Address == 3'd0 ? {spie, spe, 4'b0, div} :
                   Address == 3'd1 ? {spif, wcol, 5'b0, busy} :
                   Address == 3'd2 ? data_rx :
                   Address == 3'd3 ? ss : 8'h00;
  assign SCLK_H  = sclk;
  assign MOSI_H  = tx[7];
  assign SS_L    = ss;
  always_ff @(posedge Clk or negedge Reset_L)
    if (!Reset_L) state <= IDLE;
    else state <= state_n;
  always_comb begin
    half_end = busy && cnt >= lim;
    done     = half_end && &hc && spe_n;
    state_n  = state == IDLE ? (start ? SHIFT : IDLE) : (!spe_n || done) ? IDLE : SHIFT;
  end
  always_ff @(posedge Clk or negedge Reset_L)
    if (!Reset_L) begin
      en_q    <= 1'b0;
      Dtack_L <= 1'b1;
      IRQ_L   <= 1'b1;
      DataOut <= 8'h00;
      spie    <= 1'b0;
      spe     <= 1'b0;
      div     <= 2'd0;
      spif    <= 1'b0;
      wcol    <= 1'b0;
      data_rx <= 8'h00;
      ss      <= 8'hFF;
      tx      <= 8'h00;
      rx      <= 8'h00;
      cnt     <= 4'd0;
      hc      <= 4'd0;
      sclk    <= 1'b0;
    end else begin
      en_q    <= SPI_Enable_H;
      Dtack_L <= ~SPI_Enable_H;
      IRQ_L   <= ~(spie_n & spif_n);
      spif    <= spif_n;
      wcol    <= wcol_n;
      if (rd) DataOut <= rd_val;
      if (wr_ctrl) begin
        spie <= DataIn[7];
        spe  <= DataIn[6];
        div  <= DataIn[1:0];
      end
      if (wr_ss) ss <= DataIn;
      if (done) data_rx <= rx;
      if (start) begin
        tx   <= DataIn;
        cnt  <= 4'd0;
        hc   <= 4'd0;
        sclk <= 1'b0;
      end else if (busy && !spe_n) sclk <= 1'b0;
      else if (half_end) begin
        cnt  <= 4'd0;
        hc   <= hc + 4'd1;
        sclk <= ~sclk;
        // Sample MISO on the rising SCLK edge, present the next MOSI bit on the falling one.
        if (!sclk) rx <= {rx[6:0], MISO_H};
        else tx <= {tx[6:0], 1'b0};
      end else if (busy) cnt <= cnt + 4'd1;
    end
endmodule

// File: tb/tb_spi_master_controller.sv
// tb_spi_master_controller: directed self-checking bench for spi_master_controller.
module tb_spi_master_controller;
  logic       Clk = 0, Reset_L = 0, SPI_Enable_H = 0, WE_L = 1, MISO_H;
  logic [2:0] Address = 3'd0;
  logic [7:0] DataIn = 8'h00, DataOut, SS_L;
  logic       Dtack_L, IRQ_L, SCLK_H, MOSI_H;
  logic       loopback = 1;
  logic [7:0] miso_pat = 8'h00, mosi_cap = 8'h00;
  int cyc = 0, nrise = 0, nfall = 0, base_r = 0, base_f = 0, t = 0, w = 0;
  int errors = 0, checks = 0;
  spi_master_controller dut (
    .Clk(Clk), .Reset_L(Reset_L), .SPI_Enable_H(SPI_Enable_H), .Address(Address), .WE_L(WE_L),
    .DataIn(DataIn), .DataOut(DataOut), .Dtack_L(Dtack_L), .IRQ_L(IRQ_L), .SCLK_H(SCLK_H),
    .MOSI_H(MOSI_H), .MISO_H(MISO_H), .SS_L(SS_L)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge SCLK_H) begin
    nrise <= nrise + 1;
    mosi_cap <= {mosi_cap[6:0], MOSI_H};
  end
  always @(negedge SCLK_H) nfall <= nfall + 1;
  // Slave model: MSB first, next bit presented after each SCLK fall.
  assign MISO_H = loopback ? MOSI_H : miso_pat[3'(7 - (nfall - base_f))];
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) step(1);
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    SPI_Enable_H = 1; WE_L = 0; Address = a; DataIn = d;
    step(1);
    SPI_Enable_H = 0; WE_L = 1;
    step(1);
  endtask
  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    SPI_Enable_H = 1; WE_L = 1; Address = a;
    step(1);
    SPI_Enable_H = 0;
    check(tag, DataOut, exp);
    step(1);
  endtask
  initial begin
    #1;
    step(3);
    check("rst_sclk", SCLK_H, 0);
    check("rst_mosi", MOSI_H, 0);
    check("rst_ss", SS_L, 8'hFF);
    check("rst_dtack", Dtack_L, 1);
    check("rst_irq", IRQ_L, 1);
    check("rst_dout", DataOut, 8'h00);
    Reset_L = 1;
    step(2);
    // DIV=0 loopback transfer of 0xA5
    loopback = 1;
    wr(3'd0, 8'h40);
    base_r = nrise; t = cyc;
    wr(3'd2, 8'hA5);
    check("d0_sclk_t2", SCLK_H, 0);
    wait_cyc(t + 3); check("d0_sclk_t3", SCLK_H, 1);
    wait_cyc(t + 4); check("d0_sclk_t4", SCLK_H, 1);
    wait_cyc(t + 5); check("d0_sclk_t5", SCLK_H, 0);
    wait_cyc(t + 31); rd_chk("d0_stat_busy", 3'd1, 8'h01);
    rd_chk("d0_stat_spif", 3'd1, 8'h80);
    rd_chk("d0_data", 3'd2, 8'hA5);
    check("d0_rises", 8'(nrise - base_r), 8'd8);
    check("d0_mosi_seq", mosi_cap, 8'hA5);
    wr(3'd1, 8'h80);
    rd_chk("d0_stat_clr", 3'd1, 8'h00);
    // DIV=3, slave returns 0x3C
    loopback = 0; miso_pat = 8'h3C;
    wr(3'd0, 8'h43);
    base_f = nfall; t = cyc;
    wr(3'd2, 8'h00);
    wait_cyc(t + 16); check("d3_sclk_t16", SCLK_H, 0);
    wait_cyc(t + 17); check("d3_sclk_t17", SCLK_H, 1);
    wait_cyc(t + 32); check("d3_sclk_t32", SCLK_H, 1);
    wait_cyc(t + 33); check("d3_sclk_t33", SCLK_H, 0);
    wait_cyc(t + 255); rd_chk("d3_stat_busy", 3'd1, 8'h01);
    rd_chk("d3_stat_spif", 3'd1, 8'h80);
    rd_chk("d3_data", 3'd2, 8'h3C);
    rd_chk("d3_ctrl", 3'd0, 8'h43);
    wr(3'd1, 8'h80);
    // write collision
    loopback = 1;
    wr(3'd0, 8'h40);
    t = cyc;
    wr(3'd2, 8'h5A);
    wait_cyc(t + 5);
    wr(3'd2, 8'hFF);
    rd_chk("wcol_busy", 3'd1, 8'h41);
    wait_cyc(t + 35);
    rd_chk("wcol_done", 3'd1, 8'hC0);
    rd_chk("wcol_data", 3'd2, 8'h5A);
    wr(3'd1, 8'hC0);
    rd_chk("wcol_clr", 3'd1, 8'h00);
    // interrupt and abort
    wr(3'd0, 8'hC0);
    check("irq_idle", IRQ_L, 1);
    t = cyc;
    wr(3'd2, 8'h3C);
    wait_cyc(t + 35); check("irq_set", IRQ_L, 0);
    w = cyc;
    wr(3'd1, 8'h80);
    check("irq_clr", IRQ_L, 1);
    base_r = nrise; t = cyc;
    wr(3'd2, 8'h81);
    wait_cyc(t + 10);
    wr(3'd0, 8'h80);
    check("abort_sclk", SCLK_H, 0);
    wait_cyc(t + 16); check("abort_sclk_t16", SCLK_H, 0);
    wait_cyc(t + 40);
    rd_chk("abort_stat", 3'd1, 8'h00);
    check("abort_rises", 8'(nrise - base_r), 8'd2);
    rd_chk("abort_data", 3'd2, 8'h3C);
    check("abort_irq", IRQ_L, 1);
    // long select: one transfer, DTACK tracks the select
    wr(3'd0, 8'h40);
    base_r = nrise; t = cyc;
    SPI_Enable_H = 1; WE_L = 0; Address = 3'd2; DataIn = 8'h96;
    check("dtack_t0", Dtack_L, 1);
    wait_cyc(t + 1); check("dtack_t1", Dtack_L, 0);
    wait_cyc(t + 9); check("dtack_t9", Dtack_L, 0);
    wait_cyc(t + 10);
    SPI_Enable_H = 0; WE_L = 1;
    check("dtack_t10", Dtack_L, 0);
    wait_cyc(t + 11); check("dtack_t11", Dtack_L, 1);
    wait_cyc(t + 80);
    check("long_rises", 8'(nrise - base_r), 8'd8);
    check("long_mosi", mosi_cap, 8'h96);
    rd_chk("long_stat", 3'd1, 8'h80);
    rd_chk("long_data", 3'd2, 8'h96);
    // reset in the middle of a transfer
    wr(3'd3, 8'hFE);
    check("ss_drive", SS_L, 8'hFE);
    wr(3'd0, 8'hC0);
    check("pre_rst_irq", IRQ_L, 0);
    t = cyc;
    wr(3'd2, 8'h55);
    wait_cyc(t + 4); check("pre_rst_sclk", SCLK_H, 1);
    Reset_L = 0;
    #1;
    check("mid_rst_ss", SS_L, 8'hFF);
    check("mid_rst_sclk", SCLK_H, 0);
    check("mid_rst_dtack", Dtack_L, 1);
    check("mid_rst_irq", IRQ_L, 1);
    step(2);
    Reset_L = 1;
    step(2);
    base_r = nrise;
    rd_chk("post_ctrl", 3'd0, 8'h00);
    rd_chk("post_stat", 3'd1, 8'h00);
    rd_chk("post_data", 3'd2, 8'h00);
    rd_chk("post_ss", 3'd3, 8'hFF);
    wr(3'd4, 8'hAA);
    rd_chk("post_unmapped", 3'd4, 8'h00);
    step(20);
    check("post_rises", 8'(nrise - base_r), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master_controller.md
# spi_master_controller

Memory-mapped SPI master serving the 68k I/O window at 0x00408020–0x0040802F; it is the responder behind the SPI bus decoder's `SPI_Enable_H`. Holds control, status, data and chip-select registers, and serialises one byte at a time in SPI mode 0 to off-board flash/peripherals. Reports completion via a status flag and an optional active-low interrupt, and generates its own DTACK for the CPU bus cycle.

## Interface
- No parameters; register map and widths are fixed.
- `Clk`  in  1  system clock; all state on rising edge
- `Reset_L`  in  1  asynchronous, active-low reset
- `SPI_Enable_H`  in  1  decoded select; high for the whole 68k access (AS_L low, address in window)
- `Address`  in  3  CPU address bits [3:1]; register select
- `WE_L`  in  1  68k R/W: low = write
- `DataIn`  in  8  CPU write data (D[7:0])
- `DataOut`  out  8  CPU read data, registered
- `Dtack_L`  out  1  data acknowledge to CPU
- `IRQ_L`  out  1  interrupt request, active low
- `SCLK_H`  out  1  SPI clock, idle low
- `MOSI_H`  out  1  SPI serial out, MSB first
- `MISO_H`  in  1  SPI serial in
- `SS_L`  out  8  slave selects, active low

## Operation
- Registers (Address[3:1]):
  - 0 CTRL r/w: [7] SPIE, [6] SPE, [1:0] DIV; other bits read 0. Reset 0x00.
  - 1 STAT: [7] SPIF (transfer done), [6] WCOL, [0] BUSY. Write 1 to bit 7/6 clears it; BUSY read-only. Reset 0x00.
  - 2 DATA: write loads TX shifter and starts a transfer; read returns last received byte. Reset 0x00.
  - 3 SS r/w: drives `SS_L` directly. Reset 0xFF.
  - 4–7: reads 0x00, writes ignored, still acknowledged.
- Bus strobe: `SPI_Enable_H` high this cycle and low the previous cycle; exactly one register action per 68k cycle regardless of its length.
- Shift FSM states IDLE, SHIFT:
  - IDLE -> SHIFT on DATA write strobe with SPE=1 and BUSY=0.
  - DATA write with BUSY=1: data discarded, WCOL set, transfer unaffected.
  - DATA write with SPE=0: ignored, no WCOL.
  - SHIFT: half-period h = 2^(DIV+1) Clk (4/8/16/32 clocks per SCLK period). 16 half-periods. MOSI valid from SHIFT entry; MISO sampled on each SCLK rise; next MOSI bit presented on each SCLK fall.
  - SHIFT -> IDLE after the 16th half-period: SCLK low, DATA read value updated, SPIF set.
  - SPE cleared during SHIFT: immediate abort to IDLE, SCLK low, SPIF not set, read data unchanged.
- SPIF set and SPIF-clear write in the same cycle: set wins. Same rule for WCOL.
- `IRQ_L` = NOT(SPIE AND SPIF), registered.
- `SS_L` purely software-controlled; the block never toggles it.

## Timing
- Reset (async assert, sync deassert inside): FSM IDLE, SCLK_H=0, MOSI_H=0, SS_L=0xFF, Dtack_L=1, IRQ_L=1, DataOut=0x00, all registers at reset values.
- Write strobe at cycle T: register updated at end of T; readable from T+1.
- Read strobe at cycle T: DataOut valid from T+1.
- `Dtack_L` low from T+1 until the cycle after `SPI_Enable_H` falls; high otherwise.
- Transfer started at T: BUSY=1 and MOSI=bit7 from T+1; first SCLK rise at T+1+h; SPIF=1, BUSY=0 at T+1+16h (DIV=0: T+33).
- Reset mid-transfer: everything to reset values, no SPIF.

## Test plan
- Reset: assert `Reset_L` mid-transfer -> SS_L=0xFF, SCLK_H=0, Dtack_L=1, IRQ_L=1, all register reads return 0x00 afterwards (SS reads 0xFF).
- Loopback MOSI->MISO, CTRL=0x40, write DATA=0xA5 at T -> SCLK 8 pulses of 4 clocks, SPIF=1 at T+33, DATA reads 0xA5, MOSI sequence 1,0,1,0,0,1,0,1.
- DIV=3, MISO driven 0x3C by model -> SCLK period 32 clocks, SPIF at T+257, DATA reads 0x3C.
- Second DATA write 5 cycles after start -> WCOL=1, transfer completes with first byte; write STAT=0xC0 -> STAT reads 0x00.
- CTRL=0xC0, complete transfer -> IRQ_L=0; write STAT=0x80 -> IRQ_L=1 next cycle; clear CTRL SPE mid-transfer -> SCLK low, SPIF stays 0.
- Hold `SPI_Enable_H` high 10 cycles on a DATA write -> exactly one transfer; Dtack_L low cycles T+1..T+10, high after release.
